// File: rtl/tlb.sv
// rtl/tlb.sv - fully associative TLB in front of the page-table walker.
// Optional per-entry ASID tagging is compiled in with TLB_ASID_EN.
module tlb #(
  parameter int ENTRIES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_va,
  input  logic [63:0] satp,
  input  logic [1:0]  mmode,
  input  logic        flush,
  output logic        resp_valid,
  output logic [63:0] resp_pa,
  output logic        resp_fault,
  output logic        resp_hit,
  output logic        ptw_en,
  output logic [63:0] ptw_va,
  input  logic [63:0] ptw_pa,
  input  logic        ptw_valid,
  input  logic        ptw_done
);

  localparam int IW = $clog2(ENTRIES);

  typedef enum logic [1:0] {IDLE, HIT_RESP, WALK, WALK_RESP} state_t;

  state_t             state_q, state_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [35:0]        tag_q [ENTRIES];
  logic [35:0]        tag_d [ENTRIES];
  logic [43:0]        ppn_q [ENTRIES];
  logic [43:0]        ppn_d [ENTRIES];
  logic [IW-1:0]      rr_q, rr_d;
  logic [63:0]        va_q, va_d;
  logic [63:0]        pa_q, pa_d;
  logic               fault_q, fault_d;
  logic               hit_q, hit_d;
  logic               walk_flushed_q, walk_flushed_d;

`ifdef TLB_ASID_EN
  logic [15:0]        asid_q [ENTRIES];
  logic [15:0]        asid_d [ENTRIES];
  logic [15:0]        req_asid_q, req_asid_d;
  logic               unused_satp;
  assign unused_satp = ^satp[43:0];
`else
  logic               unused_satp;
  assign unused_satp = ^satp[59:0];
`endif

  logic               bypass;
  logic               sv39;
  logic [ENTRIES-1:0] match;
  logic               any_hit;
  logic [43:0]        hit_ppn;
  logic [IW-1:0]      victim;
  logic               found_free;
  logic               fill;

  // Lookup against the current (pre-flush) array using the live request inputs.
  always_comb begin
    bypass  = (satp[63:60] == 4'd0) || (mmode == 2'b11);
    sv39    = (satp[63:60] == 4'd8);
    match   = '0;
    hit_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = valid_q[i] &&
                 (sv39 ? (tag_q[i][26:0] == req_va[38:12]) : (tag_q[i] == req_va[47:12]));
`ifdef TLB_ASID_EN
      match[i] = match[i] && (asid_q[i] == satp[59:44]);
`endif
      if (match[i]) begin
        hit_ppn = hit_ppn | ppn_q[i];
      end
    end
    any_hit = |match;
  end

  // Lowest free entry wins; the round-robin pointer is only a fallback.
  always_comb begin
    victim     = rr_q;
    found_free = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!found_free && !valid_q[i]) begin
        victim     = i[IW-1:0];
        found_free = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    tag_d          = tag_q;
    ppn_d          = ppn_q;
    rr_d           = rr_q;
    va_d           = va_q;
    pa_d           = pa_q;
    fault_d        = fault_q;
    hit_d          = hit_q;
    walk_flushed_d = walk_flushed_q;
    fill           = 1'b0;
`ifdef TLB_ASID_EN
    asid_d         = asid_q;
    req_asid_d     = req_asid_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          va_d           = req_va;
          walk_flushed_d = 1'b0;
          fault_d        = 1'b0;
`ifdef TLB_ASID_EN
          req_asid_d     = satp[59:44];
`endif
          if (bypass || any_hit) begin
            pa_d    = bypass ? req_va : {8'b0, hit_ppn, req_va[11:0]};
            hit_d   = 1'b1;
            state_d = HIT_RESP;
          end else begin
            hit_d   = 1'b0;
            state_d = WALK;
          end
        end
      end
      HIT_RESP: state_d = IDLE;
      WALK: begin
        if (flush) begin
          walk_flushed_d = 1'b1;
        end
        if (ptw_done) begin
          hit_d   = 1'b0;
          state_d = WALK_RESP;
          if (ptw_valid) begin
            pa_d    = ptw_pa;
            fault_d = 1'b0;
            fill    = !flush && !walk_flushed_q;
          end else begin
            pa_d    = '0;
            fault_d = 1'b1;
          end
        end
      end
      WALK_RESP: state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    if (fill) begin
      valid_d[victim] = 1'b1;
      tag_d[victim]   = va_q[47:12];
      ppn_d[victim]   = ptw_pa[55:12];
`ifdef TLB_ASID_EN
      asid_d[victim]  = req_asid_q;
`endif
      if (!found_free) begin
        rr_d = rr_q + 1'b1;
      end
    end

    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      valid_q        <= '0;
      rr_q           <= '0;
      va_q           <= '0;
      pa_q           <= '0;
      fault_q        <= 1'b0;
      hit_q          <= 1'b0;
      walk_flushed_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      rr_q           <= rr_d;
      va_q           <= va_d;
      pa_q           <= pa_d;
      fault_q        <= fault_d;
      hit_q          <= hit_d;
      walk_flushed_q <= walk_flushed_d;
    end
  end

  // Entry payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      tag_q[i]  <= tag_d[i];
      ppn_q[i]  <= ppn_d[i];
`ifdef TLB_ASID_EN
      asid_q[i] <= asid_d[i];
`endif
    end
`ifdef TLB_ASID_EN
    req_asid_q <= req_asid_d;
`endif
  end

  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = (state_q == HIT_RESP) || (state_q == WALK_RESP);
  assign resp_pa    = pa_q;
  assign resp_fault = fault_q;
  assign resp_hit   = hit_q;
  assign ptw_en     = (state_q == WALK);
  assign ptw_va     = va_q;

endmodule

// File: tb/tb_tlb.sv
// tb/tb_tlb.sv - directed table-driven bench for tlb; ASID vectors need TLB_ASID_EN.
module tb_tlb;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_va;
  logic [63:0] satp;
  logic [1:0]  mmode;
  logic        flush;
  logic        resp_valid;
  logic [63:0] resp_pa;
  logic        resp_fault;
  logic        resp_hit;
  logic        ptw_en;
  logic [63:0] ptw_va;
  logic [63:0] ptw_pa;
  logic        ptw_valid;
  logic        ptw_done;

  tlb #(.ENTRIES(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va),
    .satp(satp), .mmode(mmode), .flush(flush),
    .resp_valid(resp_valid), .resp_pa(resp_pa), .resp_fault(resp_fault), .resp_hit(resp_hit),
    .ptw_en(ptw_en), .ptw_va(ptw_va), .ptw_pa(ptw_pa), .ptw_valid(ptw_valid), .ptw_done(ptw_done)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] SV39    = 64'h8000_0000_0000_0000;
  localparam logic [63:0] SV48    = 64'h9000_0000_0000_0000;
  localparam logic [63:0] SV39_A1 = 64'h8000_1000_0000_0000;
  localparam logic [63:0] SV39_A2 = 64'h8000_2000_0000_0000;

  typedef struct {
    logic [63:0] va;
    logic [63:0] satp;
    logic [1:0]  mmode;
    logic        flush_pre;
    int          flush_mode;  // 0 none, 1 during walk, 2 with ptw_done
    logic [63:0] walk_pa;
    logic        walk_ok;
    logic [63:0] exp_pa;
    logic        exp_fault;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   passed = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic [63:0] va, input logic [63:0] sp, input logic [1:0] mm,
                     input logic fpre, input int fmode, input logic [63:0] wpa, input logic wok,
                     input logic [63:0] epa, input logic efault, input logic ehit);
    vec_t v;
    v.va = va; v.satp = sp; v.mmode = mm; v.flush_pre = fpre; v.flush_mode = fmode;
    v.walk_pa = wpa; v.walk_ok = wok; v.exp_pa = epa; v.exp_fault = efault; v.exp_hit = ehit;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    string tagn;
    tagn = $sformatf("v%0d", idx);
    if (v.flush_pre) begin
      flush = 1'b1;
      step();
      flush = 1'b0;
    end
    n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    chk({tagn, " req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_va = v.va; satp = v.satp; mmode = v.mmode;
    step();
    // Scramble inputs after acceptance: the in-flight request must not see them.
    req_valid = 1'b0; req_va = '1; satp = 64'h0; mmode = 2'b11;
    if (v.exp_hit) begin
      chk({tagn, " hit resp_valid"}, 64'(resp_valid), 64'd1);
      chk({tagn, " hit resp_pa"}, resp_pa, v.exp_pa);
      chk({tagn, " hit resp_hit"}, 64'(resp_hit), 64'd1);
      chk({tagn, " hit resp_fault"}, 64'(resp_fault), 64'd0);
      chk({tagn, " hit ptw_en"}, 64'(ptw_en), 64'd0);
      step();
      chk({tagn, " hit resp_valid end"}, 64'(resp_valid), 64'd0);
      chk({tagn, " hit ready again"}, 64'(req_ready), 64'd1);
    end else begin
      chk({tagn, " miss ptw_en"}, 64'(ptw_en), 64'd1);
      chk({tagn, " miss ptw_va"}, ptw_va, v.va);
      chk({tagn, " miss no resp"}, 64'(resp_valid), 64'd0);
      step();
      if (v.flush_mode == 1) flush = 1'b1;
      step();
      flush = 1'b0;
      chk({tagn, " walk ptw_en held"}, 64'(ptw_en), 64'd1);
      ptw_done = 1'b1; ptw_valid = v.walk_ok; ptw_pa = v.walk_pa;
      if (v.flush_mode == 2) flush = 1'b1;
      step();
      flush = 1'b0;
      chk({tagn, " walk resp_valid"}, 64'(resp_valid), 64'd1);
      chk({tagn, " walk resp_pa"}, resp_pa, v.exp_pa);
      chk({tagn, " walk resp_fault"}, 64'(resp_fault), 64'(v.exp_fault));
      chk({tagn, " walk resp_hit"}, 64'(resp_hit), 64'd0);
      chk({tagn, " walk ptw_en low"}, 64'(ptw_en), 64'd0);
      step();
      ptw_done = 1'b0; ptw_valid = 1'b0;
      chk({tagn, " walk resp end"}, 64'(resp_valid), 64'd0);
      chk({tagn, " walk ready again"}, 64'(req_ready), 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // Hit/bypass rows: bypass, Sv39 miss-then-hit, faults, Sv48 tag width.
    add(64'h8000_1234, 64'h0, 2'b00, 0, 0, 0, 0, 64'h8000_1234, 0, 1);
    add(64'h1234_5678, SV39, 2'b11, 0, 0, 0, 0, 64'h1234_5678, 0, 1);
    add(64'h4000_2ABC, SV39, 2'b00, 0, 0, 64'h8765_4ABC, 1, 64'h8765_4ABC, 0, 0);
    add(64'h4000_2ABC, SV39, 2'b00, 0, 0, 0, 0, 64'h8765_4ABC, 0, 1);
    add(64'h80_4000_2ABC, SV39, 2'b00, 0, 0, 0, 0, 64'h8765_4ABC, 0, 1);
    add(64'h5000_0000, SV39, 2'b00, 0, 0, 64'hDEAD_0000, 0, 64'h0, 1, 0);
    add(64'h5000_0000, SV39, 2'b00, 0, 0, 64'hDEAD_0000, 0, 64'h0, 1, 0);
    add(64'h80_4000_2ABC, SV48, 2'b00, 0, 0, 64'h1111_2ABC, 1, 64'h1111_2ABC, 0, 0);
    add(64'h80_4000_2ABC, SV48, 2'b00, 0, 0, 0, 0, 64'h1111_2ABC, 0, 1);
    // Replacement: fill 8 then 2 more after a flush; page i is va 0x10_0123+(i<<12).
    for (int i = 0; i < 10; i++)
      add(64'h10_0123 + 64'(i << 12), SV39, 2'b00, i == 0, 0,
          64'h9000_0123 + 64'(i << 12), 1, 64'h9000_0123 + 64'(i << 12), 0, 0);
    for (int i = 2; i < 10; i++)
      add(64'h10_0123 + 64'(i << 12), SV39, 2'b00, 0, 0, 0, 0, 64'h9000_0123 + 64'(i << 12), 0, 1);
    add(64'h10_0123, SV39, 2'b00, 0, 0, 64'h9000_0123, 1, 64'h9000_0123, 0, 0);
    add(64'h10_1123, SV39, 2'b00, 0, 0, 64'h9000_1123, 1, 64'h9000_1123, 0, 0);
    add(64'h10_5123, SV39, 2'b00, 0, 0, 0, 0, 64'h9000_5123, 0, 1);
    add(64'h10_2123, SV39, 2'b00, 0, 0, 64'h9000_2123, 1, 64'h9000_2123, 0, 0);
    add(64'h10_4123, SV39, 2'b00, 0, 0, 64'h9000_4123, 1, 64'h9000_4123, 0, 0);
    add(64'h10_6123, SV39, 2'b00, 0, 0, 0, 0, 64'h9000_6123, 0, 1);
    add(64'h10_0123, SV39, 2'b00, 0, 0, 0, 0, 64'h9000_0123, 0, 1);
    add(64'h10_5123, SV39, 2'b00, 0, 0, 64'h9000_5123, 1, 64'h9000_5123, 0, 0);
    add(64'h10_7123, SV39, 2'b00, 0, 0, 0, 0, 64'h9000_7123, 0, 1);
    // Flush during walk, then flush coinciding with the fill.
    add(64'h7000_0ABC, SV39, 2'b00, 0, 1, 64'h2222_0ABC, 1, 64'h2222_0ABC, 0, 0);
    add(64'h7000_0ABC, SV39, 2'b00, 0, 0, 64'h2222_0ABC, 1, 64'h2222_0ABC, 0, 0);
    add(64'h7000_0ABC, SV39, 2'b00, 0, 0, 0, 0, 64'h2222_0ABC, 0, 1);
    add(64'h7100_0DEF, SV39, 2'b00, 0, 2, 64'h3333_1DEF, 1, 64'h3333_1DEF, 0, 0);
    add(64'h7100_0DEF, SV39, 2'b00, 0, 0, 64'h3333_1DEF, 1, 64'h3333_1DEF, 0, 0);
    add(64'h7100_0DEF, SV39, 2'b00, 0, 0, 0, 0, 64'h3333_1DEF, 0, 1);
`ifdef TLB_ASID_EN
    add(64'h7200_0111, SV39_A1, 2'b00, 0, 0, 64'h4444_0111, 1, 64'h4444_0111, 0, 0);
    add(64'h7200_0111, SV39_A2, 2'b00, 0, 0, 64'h5555_0111, 1, 64'h5555_0111, 0, 0);
    add(64'h7200_0111, SV39_A1, 2'b00, 0, 0, 0, 0, 64'h4444_0111, 0, 1);
    add(64'h7200_0111, SV39_A2, 2'b00, 0, 0, 0, 0, 64'h5555_0111, 0, 1);
`endif

    reset = 1'b1; req_valid = 1'b0; req_va = '0; satp = '0; mmode = '0; flush = 1'b0;
    ptw_pa = '0; ptw_valid = 1'b0; ptw_done = 1'b0;
    step(); step(); step();
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    chk("reset resp_pa", resp_pa, 64'd0);
    chk("reset resp_fault", 64'(resp_fault), 64'd0);
    chk("reset resp_hit", 64'(resp_hit), 64'd0);
    chk("reset ptw_en", 64'(ptw_en), 64'd0);
    chk("reset ptw_va", ptw_va, 64'd0);
    reset = 1'b0;
    step();
    chk("post reset req_ready", 64'(req_ready), 64'd1);

    // A stray ptw_done outside WALK must not produce a response.
    ptw_done = 1'b1; ptw_valid = 1'b1; ptw_pa = 64'hABCD_0000;
    step();
    ptw_done = 1'b0; ptw_valid = 1'b0;
    chk("idle done resp_valid", 64'(resp_valid), 64'd0);
    chk("idle done req_ready", 64'(req_ready), 64'd1);

    foreach (vecs[i]) begin
      v = vecs[i];
      run_vec(v, i);
    end

    // Reset mid-walk: walker enable drops, the pending response is lost, array cleared.
    req_valid = 1'b1; req_va = 64'h6000_0000; satp = SV39; mmode = 2'b00;
    step();
    req_valid = 1'b0;
    chk("rst walk ptw_en", 64'(ptw_en), 64'd1);
    reset = 1'b1;
    step();
    chk("rst walk ptw_en low", 64'(ptw_en), 64'd0);
    chk("rst walk req_ready", 64'(req_ready), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst walk no resp %0d", i), 64'(resp_valid), 64'd0);
    end
    v.va = 64'h10_7123; v.satp = SV39; v.mmode = 2'b00; v.flush_pre = 1'b0; v.flush_mode = 0;
    v.walk_pa = 64'h9000_7123; v.walk_ok = 1'b1; v.exp_pa = 64'h9000_7123;
    v.exp_fault = 1'b0; v.exp_hit = 1'b0;
    run_vec(v, 999);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tlb.md
# tlb

Fully associative translation lookaside buffer in front of the page-table walker (`translate`) in the memory stage. It accepts virtual-address lookups from the load/store path and answers hits or bare-mode bypasses from its entry array. On a miss it drives the walker's `en`/`va` inputs, captures the leaf result, fills an entry and returns the physical address or a fault.

## Interface
- `ENTRIES`, default 8: number of entries; must be a power of two, minimum 2.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  lookup request.
- `req_ready`  out  1  high only in IDLE, when a request can be accepted.
- `req_va`  in  64  virtual address, sampled at acceptance.
- `satp`  in  64  current satp: mode [63:60], asid [59:44].
- `mmode`  in  2  current privilege; 2'b11 means M-mode, no translation.
- `flush`  in  1  single-cycle sfence pulse; invalidates all entries.
- `resp_valid`  out  1  one-cycle response pulse; no backpressure.
- `resp_pa`  out  64  physical address; 0 when `resp_fault` is high.
- `resp_fault`  out  1  walk ended with an invalid PTE.
- `resp_hit`  out  1  response came from the array or from bypass, not from a walk.
- `ptw_en`  out  1  walker enable.
- `ptw_va`  out  64  walker virtual address: the latched `req_va`.
- `ptw_pa`  in  64  walker `pa`.
- `ptw_valid`  in  1  walker `valid`.
- `ptw_done`  in  1  walker `done`.

## Operation
- Entry fields: valid bit, tag vpn[35:0] = va[47:12], ppn[43:0], and asid[15:0] when the asid feature is compiled in (see Configuration).
- Translation is bypassed when satp mode == 0 or mmode == 2'b11. Bypass gives resp_pa = req_va, resp_hit = 1.
- For satp mode 8 (Sv39) the tag compares va[38:12] only; the upper tag bits are stored but ignored. For mode 9 (Sv48) the tag compares va[47:12].
- A hit returns resp_pa = {8'b0, ppn, va[11:0]}. At most one entry may match; a fill never creates a duplicate tag.
- States and transitions:
  - IDLE: if req_valid, latch va, satp and mmode. Go to HIT_RESP on hit or bypass, otherwise to WALK.
  - HIT_RESP: resp_valid = 1, then IDLE.
  - WALK: ptw_en = 1. Stay until ptw_done = 1.
    - ptw_done and ptw_valid: latch ptw_pa and fill an entry with ppn = ptw_pa[55:12].
    - ptw_done and not ptw_valid: latch fault.
    - In both cases go to WALK_RESP.
  - WALK_RESP: ptw_en = 0, so the walker leaves its DONE state. resp_valid = 1 with the latched result, resp_hit = 0. Then IDLE.
- Fill victim: the lowest-index invalid entry. If all entries are valid, the entry at the round-robin pointer; the pointer then increments modulo ENTRIES, wrapping ENTRIES-1 to 0. The pointer does not move on fills into invalid entries.
- Faults never fill.
- flush clears every valid bit in the next cycle, in any state. It does not reset the round-robin pointer.
  - Flush in the same cycle as a fill: flush wins and the entry stays invalid.
  - Flush during WALK: the walk completes and the response is delivered, but the result is not filled.
  - Flush in IDLE in the same cycle as an accepted request: the lookup uses the pre-flush array.

## Timing
- Reset values: state IDLE; req_ready = 0 during reset, 1 from the first cycle after.
- Reset values: resp_valid = 0, resp_pa = 0, resp_fault = 0, resp_hit = 0, ptw_en = 0, ptw_va = 0.
- Reset values: all valid bits 0, round-robin pointer 0.
- Hit or bypass: accepted in cycle N, resp_valid in N+1, req_ready high again in N+2.
- Miss: accepted in N, ptw_en high from N+1. ptw_done first seen in cycle M gives resp_valid in M+1 with ptw_en = 0; IDLE in M+2.
- ptw_done is ignored outside WALK. Only the first ptw_done cycle in WALK is used.
- satp and mmode changes after acceptance do not affect an in-flight request.
- reset mid-walk: ptw_en drops in the next cycle, and the pending response is discarded.

## Configuration
- `TLB_ASID_EN` defined: each entry stores satp[59:44] at fill. A hit additionally requires a stored asid equal to the current satp asid; a non-matching entry counts as a miss.
- `TLB_ASID_EN` undefined: no asid storage and asid is ignored in matching. Any satp change must be followed by a flush.

## Test plan
- Bypass: satp = 0, req_va = 0x8000_1234 -> resp_valid at N+1, resp_pa = 0x8000_1234, resp_hit = 1, ptw_en never asserted.
- Miss then hit, Sv39: va = 0x4000_2ABC, walker returns ptw_pa = 0x8765_4ABC with valid at M.
  - First request: resp_pa = 0x8765_4ABC, resp_hit = 0 at M+1, ptw_en low at M+1.
  - Same va re-requested: resp_hit = 1, same pa at N+1.
- Fault: walker gives ptw_done = 1, ptw_valid = 0 -> resp_fault = 1, resp_pa = 0. Repeating the va walks again.
- Replacement and wrap, ENTRIES = 8: fill 8 distinct pages, then 2 more. Victims are entries 0 and 1. Pages 0 and 1 then miss; pages 2–7 hit.
- Flush: flush pulsed during WALK -> the response is still delivered, and the next lookup of the same va misses. Also check flush in the same cycle as the fill.
- ASID, with `TLB_ASID_EN`: fill under asid 1, switch satp to asid 2, same va -> miss. Switch back to asid 1 -> hit.
